// File: rtl/seq_pkg.sv
// seq_pkg: shared width defaults and 1011 detector state encodings
package seq_pkg;
    localparam int TS_W_DEF  = 16;
    localparam int CNT_W_DEF = 16;
    localparam int DEPTH_DEF = 8;
    typedef enum logic [2:0] {IDLE, SEQ_1, SEQ_10, SEQ_101, SEQ_1011} det_state_e;
endpackage

// File: rtl/seq_sync_fifo.sv
// seq_sync_fifo: timestamp FIFO with registered head, level-based full/empty
module seq_sync_fifo import seq_pkg::*; #(
    parameter int DEPTH = DEPTH_DEF,
    parameter int W     = TS_W_DEF,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, rd_nxt;
    logic [LW-1:0] lvl_nxt;
    logic          do_push, do_pop;
    assign full  = level == LW'(DEPTH);
    assign empty = level == '0;
    // a pop frees the slot a same-cycle push into a full FIFO needs
    always_comb begin
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        rd_nxt  = do_pop ? rd_ptr + 1'b1 : rd_ptr;
        lvl_nxt = level + LW'(do_push) - LW'(do_pop);
    end
    // storage array, no reset needed since level gates visibility
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
    // pointers, occupancy and registered head; head holds its value when empty
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
            dout   <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            rd_ptr <= rd_nxt;
            wr_ptr <= wr_ptr + AW'(do_push);
            level  <= lvl_nxt;
            dout   <= lvl_nxt == '0 ? dout : (do_push && wr_ptr == rd_nxt) ? din : mem[rd_nxt];
        end
    end
endmodule

// File: rtl/seq_event_logger.sv
// seq_event_logger: counts and timestamps sequence detections into a FIFO
module seq_event_logger import seq_pkg::*; #(
    parameter int TS_W     = TS_W_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int EVT_EDGE = 0,
    localparam int LW      = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             seq_seen,
    input  logic             enable,
    input  logic             clear,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [TS_W-1:0]  ev_ts,
    output logic [CNT_W-1:0] hit_count,
    output logic             overflow,
    output logic [LW-1:0]    level
);
    logic [TS_W-1:0] ts;
    logic            seq_q, evt, full, empty;
    assign ev_valid = ~empty;
    // event qualification: level or rising-edge mode, gated by enable
    always_comb evt = enable & (EVT_EDGE != 0 ? seq_seen & ~seq_q : seq_seen);
    // free-running timestamp and edge history, untouched by clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts    <= '0;
            seq_q <= 1'b0;
        end else begin
            ts    <= ts + 1'b1;
            seq_q <= seq_seen;
        end
    end
    // saturating hit counter and sticky overflow on a dropped event
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_count <= '0;
            overflow  <= 1'b0;
        end else if (clear) begin
            hit_count <= '0;
            overflow  <= 1'b0;
        end else begin
            hit_count <= (evt && hit_count != '1) ? hit_count + 1'b1 : hit_count;
            overflow  <= overflow | (evt & full & ~ev_ready);
        end
    end
    seq_sync_fifo #(.DEPTH(DEPTH), .W(TS_W)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (evt & ~clear),
        .pop     (ev_ready),
        .flush   (clear),
        .din     (ts),
        .dout    (ev_ts),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );
endmodule

// File: tb/tb_seq_event_logger.sv
// tb_seq_event_logger: directed vectors plus random stimulus against a queue model
module tb_seq_event_logger;
    import seq_pkg::*;
    logic clk = 0, reset_n = 0, seq = 0, en = 0, clr = 0, rdy = 0;
    logic a_valid, a_ovf, b_valid, b_ovf;
    logic [15:0] a_ts, a_hit;
    logic [3:0]  a_lvl, b_ts, b_hit;
    logic [2:0]  b_lvl;
    int checks = 0, errors = 0;
    int unsigned mq [2][$];
    int unsigned mhit [2], mlast [2], tcur;
    bit movf [2], mknown [2], mprev [2], m_ev, run_chk = 0;

    seq_event_logger #(.TS_W(16), .CNT_W(16), .DEPTH(8), .EVT_EDGE(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .seq_seen(seq), .enable(en), .clear(clr),
        .ev_valid(a_valid), .ev_ready(rdy), .ev_ts(a_ts), .hit_count(a_hit),
        .overflow(a_ovf), .level(a_lvl));
    seq_event_logger #(.TS_W(4), .CNT_W(4), .DEPTH(4), .EVT_EDGE(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .seq_seen(seq), .enable(en), .clear(clr),
        .ev_valid(b_valid), .ev_ready(rdy), .ev_ts(b_ts), .hit_count(b_hit),
        .overflow(b_ovf), .level(b_lvl));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int idx, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0d want %0d", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input bit s, input bit e, input bit c, input bit r);
        seq = s; en = e; clr = c; rdy = r;
        @(negedge clk);
    endtask

    // reference model: instance 0 = level mode 16/16/8, instance 1 = edge mode 4/4/4
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tcur = 0;
            for (int i = 0; i < 2; i++) begin
                mq[i].delete(); mhit[i] = 0; movf[i] = 0; mlast[i] = 0; mknown[i] = 1; mprev[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_ev = en && (i == 1 ? (seq && !mprev[i]) : seq);
                mprev[i] = seq;
                if (clr) begin
                    mq[i].delete(); mhit[i] = 0; movf[i] = 0; mknown[i] = 0;
                end else begin
                    if (rdy && mq[i].size() != 0) begin
                        mlast[i] = mq[i].pop_front(); mknown[i] = 1;
                    end
                    if (m_ev) begin
                        if (mhit[i] < (i == 1 ? 15 : 65535)) mhit[i]++;
                        if (mq[i].size() < (i == 1 ? 4 : 8)) mq[i].push_back(tcur % (i == 1 ? 16 : 65536));
                        else movf[i] = 1;
                    end
                end
            end
            tcur++;
        end
    end

    always @(negedge clk) begin
        if (reset_n && run_chk) begin
            for (int i = 0; i < 2; i++) begin
                chk("m_valid", i, i ? b_valid : a_valid, mq[i].size() != 0);
                chk("m_level", i, i ? b_lvl : a_lvl, mq[i].size());
                chk("m_hit", i, i ? b_hit : a_hit, mhit[i]);
                chk("m_ovf", i, i ? b_ovf : a_ovf, movf[i]);
                if (mq[i].size() != 0 || mknown[i])
                    chk("m_ts", i, i ? b_ts : a_ts, mq[i].size() != 0 ? mq[i][0] : mlast[i]);
            end
        end
    end

    typedef struct {bit s, e, c, r, v; int lvl, hit, ts; bit cts;} vec_t;
    vec_t tv [11];
    int unsigned t0;

    initial begin
        tv[0]  = '{0,1,0,0, 0, 0,0,0, 1};
        tv[1]  = '{0,1,0,0, 0, 0,0,0, 1};
        tv[2]  = '{0,1,0,0, 0, 0,0,0, 1};
        tv[3]  = '{0,1,0,0, 0, 0,0,0, 1};
        tv[4]  = '{0,1,0,0, 0, 0,0,0, 1};
        tv[5]  = '{1,1,0,0, 1, 1,1,5, 1};
        tv[6]  = '{0,1,0,1, 0, 0,1,5, 1};
        tv[7]  = '{1,1,0,0, 1, 1,2,7, 1};
        tv[8]  = '{1,1,0,1, 1, 1,3,8, 1};
        tv[9]  = '{0,1,1,0, 0, 0,0,0, 0};
        tv[10] = '{1,0,0,0, 0, 0,0,0, 0};
        repeat (3) @(negedge clk);
        chk("rst_valid", 0, a_valid, 0);
        chk("rst_ts", 0, a_ts, 0);
        chk("rst_hit", 0, a_hit, 0);
        chk("rst_ovf", 0, a_ovf, 0);
        chk("rst_level", 0, a_lvl, 0);
        chk("rst_valid", 1, b_valid, 0);
        chk("rst_level", 1, b_lvl, 0);
        reset_n = 1;
        run_chk = 1;
        for (int k = 0; k < 11; k++) begin
            drive(tv[k].s, tv[k].e, tv[k].c, tv[k].r);
            chk("tv_valid", k, a_valid, tv[k].v);
            chk("tv_level", k, a_lvl, tv[k].lvl);
            chk("tv_hit", k, a_hit, tv[k].hit);
            if (tv[k].cts) chk("tv_ts", k, a_ts, tv[k].ts);
        end
        drive(0, 1, 1, 0);
        t0 = tcur;
        repeat (9) drive(1, 1, 0, 0);
        drive(0, 1, 0, 0);
        chk("ovf_level", 0, a_lvl, 8);
        chk("ovf_hit", 0, a_hit, 9);
        chk("ovf_flag", 0, a_ovf, 1);
        for (int k = 0; k < 8; k++) begin
            chk("drain_ts", k, a_ts, (t0 + k) & 32'hffff);
            drive(0, 1, 0, 1);
        end
        chk("drain_empty", 0, a_valid, 0);
        drive(0, 1, 1, 0);
        repeat (8) drive(1, 1, 0, 0);
        drive(0, 1, 0, 0);
        chk("full_level", 0, a_lvl, 8);
        chk("full_ovf", 0, a_ovf, 0);
        drive(1, 1, 0, 1);
        chk("pp_level", 0, a_lvl, 8);
        chk("pp_ovf", 0, a_ovf, 0);
        chk("pp_hit", 0, a_hit, 9);
        drive(0, 1, 1, 0);
        repeat (3) drive(1, 1, 0, 0);
        chk("clr_pre", 0, a_lvl, 3);
        drive(1, 1, 1, 0);
        chk("clr_level", 0, a_lvl, 0);
        chk("clr_hit", 0, a_hit, 0);
        chk("clr_valid", 0, a_valid, 0);
        drive(0, 1, 1, 0);
        repeat (4) drive(1, 1, 0, 0);
        drive(0, 1, 0, 0);
        chk("lvl_hit", 0, a_hit, 4);
        chk("edge_hit", 1, b_hit, 1);
        chk("edge_level", 1, b_lvl, 1);
        drive(1, 0, 0, 0);
        drive(0, 1, 0, 0);
        chk("dis_hit", 0, a_hit, 4);
        chk("dis_hit", 1, b_hit, 1);
        drive(0, 1, 1, 0);
        repeat (7) drive(1, 1, 0, 0);
        repeat (2) drive(0, 1, 0, 1);
        rdy = 0;
        chk("mid_level", 0, a_lvl, 5);
        #2 reset_n = 0;
        #1;
        chk("arst_valid", 0, a_valid, 0);
        chk("arst_ts", 0, a_ts, 0);
        chk("arst_hit", 0, a_hit, 0);
        chk("arst_ovf", 0, a_ovf, 0);
        chk("arst_level", 0, a_lvl, 0);
        chk("arst_level", 1, b_lvl, 0);
        chk("arst_hit", 1, b_hit, 0);
        @(negedge clk);
        reset_n = 1;
        for (int k = 0; k < 3000; k++)
            drive($urandom_range(0, 2) != 0, ($urandom % 8) != 0, ($urandom % 256) == 0,
                  ((k / 400) % 2) != 0 ? ($urandom % 4) != 0 : ($urandom % 5) == 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
